wave_display_multi: RTL and testbench

WAVE_DISPLAY_MULTI -- requirements
Module: wave_display_multi

---
 rtl/wave_display_multi.sv | 138 +++++++++++++
 tb/tb_wave_display_multi.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_display_multi.sv
// rtl/wave_display_multi.sv - multi-trace waveform overlay for a scanning pixel stream
// Two-stage pipeline: stage 0 addresses the sample RAM, stage 1 holds the pixel while the sample returns.
module wave_display_multi #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 8,
    parameter int X_START   = 256,
    parameter int LINE_MODE = 1,
    parameter int GRID      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           x,
    input  logic [9:0]            y,
    input  logic                  valid,
    input  logic                  read_index,
    input  logic [8*NUM_CH-1:0]   read_value,
    output logic [ADDR_W:0]       read_address,
    output logic                  valid_pixel,
    output logic [7:0]            r,
    output logic [7:0]            g,
    output logic [7:0]            b
);
    localparam logic [10:0] XS   = 11'(X_START);
    localparam logic [11:0] SPAN = 12'(1 << (ADDR_W + 1));

    logic [10:0]       x_rel;
    logic              window;
    logic              buf_sel;
    logic [ADDR_W:0]   addr_now;
    logic [ADDR_W:0]   addr_q;
    logic              s1_win;
    logic              s1_odd;
    logic              s1_first;
    logic [7:0]        s1_row;
    logic [7:0]        cur     [NUM_CH];
    logic [7:0]        prev    [NUM_CH];
    logic [7:0]        cur_nx  [NUM_CH];
    logic [7:0]        prev_nx [NUM_CH];
    logic [NUM_CH-1:0] hit;
    logic              px_valid;
    logic [23:0]       px_rgb;
    logic              unused_bits;

    function automatic logic [23:0] palette(input int c);
        case (c)
            0:       return 24'hFFFF00;
            1:       return 24'h00FFFF;
            2:       return 24'hFF00FF;
            default: return 24'h00FF00;
        endcase
    endfunction

    assign x_rel        = x - XS;
    assign window       = valid && (x >= XS) && ({1'b0, x_rel} < SPAN) && !y[9];
    assign addr_now     = {buf_sel, x_rel[ADDR_W:1]};
    assign read_address = window ? addr_now : addr_q;
    assign unused_bits  = y[0];

    // Each sample covers two columns; only the even column fetches a new sample.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cur_nx[c]  = s1_odd ? cur[c] : read_value[8*c +: 8];
            prev_nx[c] = s1_odd ? prev[c] : (s1_first ? read_value[8*c +: 8] : cur[c]);
        end
    end

    always_comb begin
        logic [7:0] t_cur;
        logic [7:0] t_prev;
        hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            t_cur  = ~cur_nx[c];
            t_prev = ~prev_nx[c];
            if (LINE_MODE != 0) begin
                hit[c] = (s1_row >= ((t_cur < t_prev) ? t_cur : t_prev)) &&
                         (s1_row <= ((t_cur < t_prev) ? t_prev : t_cur));
            end else begin
                hit[c] = (s1_row == t_cur);
            end
        end
    end

    // Scan from highest channel down so the lowest-index hit overwrites last.
    always_comb begin
        px_valid = 1'b0;
        px_rgb   = 24'h000000;
        if (s1_win) begin
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (hit[c]) begin
                    px_valid = 1'b1;
                    px_rgb   = palette(c);
                end
            end
            if (!px_valid && (GRID != 0) && (s1_row == 8'd128)) begin
                px_valid = 1'b1;
                px_rgb   = 24'h404040;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_sel     <= 1'b0;
            addr_q      <= '0;
            s1_win      <= 1'b0;
            s1_odd      <= 1'b0;
            s1_first    <= 1'b0;
            s1_row      <= 8'd0;
            valid_pixel <= 1'b0;
            r           <= 8'd0;
            g           <= 8'd0;
            b           <= 8'd0;
            for (int c = 0; c < NUM_CH; c++) begin
                cur[c]  <= 8'd0;
                prev[c] <= 8'd0;
            end
        end else begin
            if (valid && (x == 11'd0) && (y == 10'd0)) begin
                buf_sel <= read_index;
            end
            if (window) begin
                addr_q <= addr_now;
            end
            s1_win   <= window;
            s1_odd   <= x_rel[0];
            s1_first <= (x_rel == 11'd0);
            s1_row   <= y[8:1];
            if (s1_win) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    cur[c]  <= cur_nx[c];
                    prev[c] <= prev_nx[c];
                end
            end
            valid_pixel   <= px_valid;
            {r, g, b}     <= px_rgb;
        end
    end
endmodule

// File: tb/tb_wave_display_multi.sv
// tb/tb_wave_display_multi.sv - self-checking bench for wave_display_multi
// Line-mode and dot-mode instances share one stimulus stream and one sample RAM.
module tb_wave_display_multi;
    localparam logic [24:0] YEL = 25'h1FFFF00;
    localparam logic [24:0] CYA = 25'h100FFFF;
    localparam logic [24:0] GRY = 25'h1404040;
    localparam logic [24:0] OFF = 25'h0000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic        read_index = 1'b0;
    logic [10:0] x = 11'd0;
    logic [9:0]  y = 10'd0;
    logic [15:0] read_value = 16'd0;
    logic [15:0] read_value0 = 16'd0;
    logic [8:0]  ra, ra0;
    logic        vp, vp0;
    logic [7:0]  r, g, b, r0, g0, b0;

    always #5 clk = ~clk;

    wave_display_multi #(.NUM_CH(2), .ADDR_W(8), .X_START(256), .LINE_MODE(1), .GRID(1)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid), .read_index(read_index),
        .read_value(read_value), .read_address(ra), .valid_pixel(vp), .r(r), .g(g), .b(b));

    wave_display_multi #(.NUM_CH(2), .ADDR_W(8), .X_START(256), .LINE_MODE(0), .GRID(1)) dut0 (
        .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid), .read_index(read_index),
        .read_value(read_value0), .read_address(ra0), .valid_pixel(vp0), .r(r0), .g(g0), .b(b0));

    logic [15:0] mem [2][256];
    always @(posedge clk) begin
        read_value  <= mem[ra[8]][ra[7:0]];
        read_value0 <= mem[ra0[8]][ra0[7:0]];
    end

    int tests = 0;
    int failed = 0;

    int          m_buf = 0;
    logic [7:0]  m_cur [2] = '{8'd0, 8'd0};
    logic [7:0]  m_prev [2] = '{8'd0, 8'd0};
    logic [8:0]  m_hold = 9'd0;
    logic [24:0] e1_in = OFF, e0_in = OFF;
    logic [24:0] s1a = OFF, s2a = OFF, s1b = OFF, s2b = OFF;
    logic [8:0]  ea_in = 9'd0;
    int          tag_in = -1, tg1 = -1, tg2 = -1;
    bit          rd_idx = 1'b0;
    logic [24:0] rec1 [800];
    logic [24:0] rec0 [800];
    logic [8:0]  reca [800];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Trace row for sample v is 255-v; a line spans the previous and current sample rows.
    function automatic logic [24:0] model_px(input bit line, input int row);
        int lit, tc, tp, lo, hi;
        bit h;
        lit = -1;
        for (int c = 0; c < 2; c++) begin
            tc = 255 - int'(m_cur[c]);
            tp = 255 - int'(m_prev[c]);
            lo = (tc < tp) ? tc : tp;
            hi = (tc < tp) ? tp : tc;
            h  = line ? (row >= lo && row <= hi) : (row == tc);
            if (h && lit < 0) lit = c;
        end
        if (lit == 0) return YEL;
        if (lit == 1) return CYA;
        if (row == 128) return GRY;
        return OFF;
    endfunction

    task automatic drive(input int xi, input int yi, input bit v, input bit rst);
        int xr, idx;
        bit win;
        logic [8:0] addr;
        logic [15:0] word;
        @(negedge clk);
        x = 11'(xi); y = 10'(yi); valid = v; reset = rst; read_index = rd_idx;
        win = v && xi >= 256 && xi < 768 && yi < 512;
        xr = xi - 256;
        idx = win ? xr / 2 : 0;
        tag_in = v ? xi : -1;
        if (rst) begin
            m_buf = 0; m_hold = 9'd0;
            for (int c = 0; c < 2; c++) begin m_cur[c] = 8'd0; m_prev[c] = 8'd0; end
            e1_in = OFF; e0_in = OFF;
            ea_in = win ? {1'b0, 8'(idx)} : 9'd0;
        end else begin
            if (v && xi == 0 && yi == 0) m_buf = int'(rd_idx);
            if (win) begin
                addr = {m_buf[0], 8'(idx)};
                m_hold = addr; ea_in = addr;
                if (xr % 2 == 0) begin
                    word = mem[m_buf][idx];
                    for (int c = 0; c < 2; c++) begin
                        m_prev[c] = (xr == 0) ? word[8*c +: 8] : m_cur[c];
                        m_cur[c]  = word[8*c +: 8];
                    end
                end
                e1_in = model_px(1'b1, yi / 2);
                e0_in = model_px(1'b0, yi / 2);
            end else begin
                ea_in = m_hold; e1_in = OFF; e0_in = OFF;
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            s1a = OFF; s1b = OFF; s2a = OFF; s2b = OFF;
        end else begin
            s2a = s1a; s2b = s1b; s1a = e1_in; s1b = e0_in;
        end
        tg2 = tg1; tg1 = tag_in;
        #1;
        chk("pix_line", 32'({vp, r, g, b}), 32'(s2a));
        chk("pix_dot", 32'({vp0, r0, g0, b0}), 32'(s2b));
        chk("addr_line", 32'(ra), 32'(ea_in));
        chk("addr_dot", 32'(ra0), 32'(ea_in));
        if (tg2 >= 0) begin
            rec1[tg2] = {vp, r, g, b};
            rec0[tg2] = {vp0, r0, g0, b0};
        end
        if (tag_in >= 0) reca[tag_in] = ra;
    end

    task automatic scan_line(input int yy, input int tog_x, input int rst_x, input int gap);
        bit v;
        for (int xi = 0; xi < 800; xi++) begin
            v = !(gap > 0 && int'($urandom_range(0, 99)) < gap);
            if (xi == tog_x) rd_idx = ~rd_idx;
            drive(xi, yy, v, xi == rst_x);
        end
        drive(0, yy, 1'b0, 1'b0);
        drive(0, yy, 1'b0, 1'b0);
    endtask

    task automatic fill(input int bi, input logic [7:0] c0, input logic [7:0] c1);
        for (int i = 0; i < 256; i++) mem[bi][i] = {c1, c0};
    endtask

    initial begin
        fill(0, 8'd0, 8'd0);
        fill(1, 8'd0, 8'd0);
        drive(0, 0, 1'b0, 1'b1);
        drive(0, 0, 1'b0, 1'b1);
        drive(0, 0, 1'b0, 1'b0);
        drive(0, 0, 1'b0, 1'b0);
        chk("reset_addr", 32'(ra), 32'd0);
        chk("reset_pix", 32'({vp, r, g, b}), 32'(OFF));

        fill(0, 8'd127, 8'd127);
        fill(1, 8'd127, 8'd127);
        scan_line(0, -1, -1, 0);
        scan_line(256, -1, -1, 0);
        chk("mid_x256", 32'(rec1[256]), 32'(YEL));
        chk("mid_x767", 32'(rec1[767]), 32'(YEL));
        chk("mid_dot_x500", 32'(rec0[500]), 32'(YEL));
        chk("mid_x255", 32'(rec1[255]), 32'(OFF));
        chk("mid_x768", 32'(rec1[768]), 32'(OFF));

        fill(0, 8'd200, 8'd0);
        mem[0][10] = 16'h0000;
        mem[0][11] = 16'h00FF;
        scan_line(200, -1, -1, 0);
        chk("step_line_278", 32'(rec1[278]), 32'(YEL));
        chk("step_line_279", 32'(rec1[279]), 32'(YEL));
        chk("step_dot_row100", 32'(rec0[278]), 32'(OFF));
        scan_line(0, -1, -1, 0);
        chk("step_dot_row0", 32'(rec0[279]), 32'(YEL));
        scan_line(511, -1, -1, 0);
        chk("step_line_row255", 32'(rec1[278]), 32'(YEL));

        fill(0, 8'd50, 8'd50);
        scan_line(410, -1, -1, 0);
        chk("prio_yellow", 32'(rec1[300]), 32'(YEL));
        fill(0, 8'd250, 8'd50);
        scan_line(410, -1, -1, 0);
        chk("prio_cyan_line", 32'(rec1[300]), 32'(CYA));
        chk("prio_cyan_dot", 32'(rec0[300]), 32'(CYA));

        fill(0, 8'd127, 8'd127);
        scan_line(512, -1, -1, 0);
        chk("y512_off", 32'(rec1[300]), 32'(OFF));
        fill(0, 8'd0, 8'd0);
        scan_line(256, -1, -1, 0);
        chk("grid_line", 32'(rec1[300]), 32'(GRY));
        chk("grid_dot", 32'(rec0[300]), 32'(GRY));
        chk("grid_x255", 32'(rec1[255]), 32'(OFF));

        fill(0, 8'd127, 8'd127);
        fill(1, 8'd60, 8'd60);
        scan_line(100, 400, -1, 0);
        chk("buf_hold_same_line", 32'(reca[500]), 32'h07A);
        scan_line(101, -1, -1, 0);
        chk("buf_hold_next_line", 32'(reca[300]), 32'h016);
        scan_line(0, -1, -1, 0);
        chk("buf_flip_frame", 32'(reca[300]), 32'h116);

        fill(1, 8'd127, 8'd127);
        scan_line(256, -1, 500, 0);
        chk("rst_x499", 32'(rec1[499]), 32'(OFF));
        chk("rst_x500", 32'(rec1[500]), 32'(OFF));
        chk("rst_x501", 32'(rec1[501]), 32'(GRY));
        chk("rst_x502", 32'(rec1[502]), 32'(YEL));
        chk("rst_addr_hold", 32'(ra), 32'(9'd255));

        for (int i = 0; i < 16; i++) begin
            for (int bi = 0; bi < 2; bi++)
                for (int k = 0; k < 256; k++) mem[bi][k] = 16'($urandom);
            rd_idx = 1'($urandom_range(0, 1));
            scan_line((i % 4 == 0) ? 0 : int'($urandom_range(0, 599)), -1,
                      (i % 5 == 3) ? int'($urandom_range(0, 799)) : -1, 5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
